mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline; the consumer of the EX/MEM pipeline register outputs (ALU result, store data, rd address, write-back enable).
- Non-memory instructions: passes the ALU result to the MEM/WB register.
- Loads/stores: issues a request/ready/rvalid transaction to data memory, generates byte enables, sign/zero-extends load data.
- Stalls upstream until the access completes.

Parameters:
- TIMEOUT, 16: max cycles spent in REQ+RESP before the access is aborted; counter width $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- alu_out  in  32  ALU result / effective address
- src2_st1  in  32  store data
- rd_addr_mem  in  5  destination register
- wb_en_mem  in  1  write-back enable
- mem_read  in  1  load
- mem_write  in  1  store
- funct3  in  3  access size/sign (000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu)
- dm_req  out  1  memory request valid
- dm_we  out  1  1=write, 0=read
- dm_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dm_wdata  out  32  replicated store data
- dm_be  out  4  byte enables
- dm_ready  in  1  request accepted this cycle
- dm_rvalid  in  1  read data valid
- dm_rdata  in  32  read data word
- stall  out  1  hold IF/ID/EX/EX_MEM stages
- wb_data  out  32  MEM/WB result
- rd_addr_wb  out  5  MEM/WB destination
- wb_en_wb  out  1  MEM/WB write enable
- mem_err  out  1  one-cycle registered error pulse

Behaviour:
- Sync reset: state=IDLE; wb_data=0, rd_addr_wb=0, wb_en_wb=0, mem_err=0; dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, dm_be=0; timeout counter=0. Applies mid-transaction: the request is dropped next cycle; a dm_rvalid arriving after reset is ignored.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE with no memory op (mem_read=mem_write=0):
  - stall=0.
  - Next edge: wb_data<=alu_out, rd_addr_wb<=rd_addr_mem, wb_en_wb<=wb_en_mem (latency 1).
- IDLE error check, one of:
  - mem_read&&mem_write both set;
  - reserved funct3 (load: 011/110/111; store: anything but 000/001/010);
  - misaligned: half with addr[0]=1, word with addr[1:0]!=0.
  Response: no request issued, stall=0, next edge wb_en_wb<=0 and mem_err<=1; stays IDLE.
- IDLE with valid memory op:
  - stall=1 combinationally.
  - Edge: capture dm_we, dm_addr, dm_wdata, dm_be, funct3, addr[1:0]; counter cleared; go to REQ.
- REQ:
  - dm_req=1, all dm_* outputs held stable; stall=1.
  - dm_ready=1: store goes to DONE; load goes to RESP.
- RESP:
  - dm_req=0, stall=1.
  - dm_rvalid=1: capture extracted data, go to DONE.
  - dm_rvalid is never honoured in the same cycle as dm_ready.
- Timeout: counter increments each cycle in REQ/RESP. On reaching TIMEOUT: abort to DONE with error flag set, dm_req=0.
- DONE:
  - stall=0 for exactly one cycle; EX/MEM inputs still hold the same instruction.
  - Edge: MEM/WB register loads rd_addr_mem; go to IDLE.
  - wb_en_wb: load = wb_en_mem; store = 0; aborted = 0.
  - wb_data: load = extracted data; store = alu_out.
  - mem_err <= 1 if aborted.
  - DONE always returns to IDLE, so the same instruction is never relaunched.
- While stall=1, the MEM/WB register inserts a bubble: wb_en_wb<=0, wb_data/rd_addr_wb hold.
- mem_err: 0 on every cycle without an error event.
- Store encoding:
  - sb: dm_be = 4'b0001<<addr[1:0], dm_wdata = {4{src2[7:0]}}
  - sh: dm_be = addr[1] ? 1100 : 0011, dm_wdata = {2{src2[15:0]}}
  - sw: dm_be = 1111, dm_wdata = src2
- Load extraction:
  - Byte selected by addr[1:0], half by addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw whole word.
- dm_ready outside REQ and dm_rvalid outside RESP are ignored.
- Minimum latencies: non-memory 1 cycle; store 3 cycles (IDLE, REQ, DONE); load 4 cycles.

Test Plan:
- ALU op alu_out=0x0000_1234, rd=5, wb_en=1, no mem -> next cycle wb_data=0x1234, rd_addr_wb=5, wb_en_wb=1, stall never high, dm_req=0.
- sb addr=0x103, src2=0x0000_00AB, dm_ready=1 first REQ cycle -> dm_addr=0x100, dm_be=1000, dm_wdata=0xABABABAB; stall high 2 cycles; wb_en_wb=0.
- lb addr=0x202, dm_ready after 2 REQ cycles, dm_rvalid 3 cycles later with rdata=0x1280_FF00, rd=7 -> wb_data=0xFFFF_FF80, wb_en_wb=1; lbu same -> 0x0000_0080; stall deasserted only in DONE.
- lw addr=0x301 -> mem_err pulses 1 cycle, dm_req never asserted, wb_en_wb=0, no stall; mem_read=mem_write=1 gives the same response.
- Load with dm_ready held 0 and TIMEOUT=16 -> dm_req high 16 cycles then drops, mem_err=1, wb_en_wb=0, FSM back to IDLE.
- rst asserted in RESP, then a stray dm_rvalid -> all outputs 0 next cycle, dm_req=0, stray rvalid ignored, following ALU op completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MEM stage of a 5-stage RV32I pipeline. Non-memory instructions
//            pass the ALU result straight to the MEM/WB register. Loads and
//            stores run a request/ready/rvalid transaction against data
//            memory, with byte-enable generation, store-data replication and
//            load sign/zero extension. Upstream stages are stalled until the
//            access completes or is aborted by the timeout.
// Ports    : clk, rst                       - clock, synchronous active-high reset
//            alu_out, src2_st1, rd_addr_mem,
//            wb_en_mem, mem_read, mem_write,
//            funct3                         - EX/MEM pipeline register outputs
//            dm_req, dm_we, dm_addr,
//            dm_wdata, dm_be                - data memory request side
//            dm_ready, dm_rvalid, dm_rdata  - data memory response side
//            stall                          - hold IF/ID/EX/EX_MEM
//            wb_data, rd_addr_wb, wb_en_wb  - MEM/WB pipeline register
//            mem_err                        - one-cycle error pulse
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out,
  input  logic [31:0] src2_st1,
  input  logic [4:0]  rd_addr_mem,
  input  logic        wb_en_mem,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ready,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_addr_wb,
  output logic        wb_en_wb,
  output logic        mem_err
);

  localparam int                 c_cnt_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic [2:0]         r_funct3;
  logic [1:0]         r_off;
  logic [31:0]        r_load_data;
  logic               r_abort;

  logic               w_mem_op;
  logic               w_bad_f3;
  logic               w_misalign;
  logic               w_err;
  logic               w_launch;
  logic               w_timeout;
  logic               w_abort_set;
  logic               w_capture_load;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load_val;

  // --------------------------------------------------------------------------
  // Request decode (only meaningful while IDLE)
  // --------------------------------------------------------------------------
  assign w_mem_op = mem_read | mem_write;

  // Loads accept 000/001/010/100/101; stores accept 000/001/010 only.
  always_comb begin
    if (mem_read) begin
      w_bad_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    end else begin
      w_bad_f3 = funct3[2] || (funct3[1:0] == 2'b11);
    end
  end

  assign w_misalign = ((funct3[1:0] == 2'b01) && alu_out[0]) ||
                      ((funct3[1:0] == 2'b10) && (alu_out[1:0] != 2'b00));

  assign w_err    = w_mem_op && ((mem_read && mem_write) || w_bad_f3 || w_misalign);
  assign w_launch = w_mem_op && !w_err;

  // Store lane placement: data is replicated across the word so the byte
  // enables alone select which lanes the memory actually writes.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = src2_st1;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << alu_out[1:0];
        w_wdata = {4{src2_st1[7:0]}};
      end
      2'b01: begin
        w_be    = alu_out[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{src2_st1[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = src2_st1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Load data extraction from the returned word
  // --------------------------------------------------------------------------
  always_comb begin
    case (r_off)
      2'd0:    w_byte = dm_rdata[7:0];
      2'd1:    w_byte = dm_rdata[15:8];
      2'd2:    w_byte = dm_rdata[23:16];
      default: w_byte = dm_rdata[31:24];
    endcase
  end

  assign w_half = r_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'd0, w_byte};
      3'b101:  w_load_val = {16'd0, w_half};
      default: w_load_val = dm_rdata;
    endcase
  end

  // Last permitted cycle of REQ+RESP; the access aborts if it has not
  // completed by the end of this cycle.
  assign w_timeout = (r_cnt == c_cnt_last);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state   = r_state;
    stall          = 1'b0;
    dm_req         = 1'b0;
    w_abort_set    = 1'b0;
    w_capture_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          stall        = 1'b1;
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        dm_req = 1'b1;
        stall  = 1'b1;
        // A load accepted on the final permitted cycle could never receive
        // its data in time, so the timeout takes precedence for loads.
        if (dm_ready && r_we) begin
          w_next_state = S_DONE;
        end else if (w_timeout) begin
          w_next_state = S_DONE;
          w_abort_set  = 1'b1;
        end else if (dm_ready) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        stall = 1'b1;
        if (dm_rvalid) begin
          w_next_state   = S_DONE;
          w_capture_load = 1'b1;
        end else if (w_timeout) begin
          w_next_state = S_DONE;
          w_abort_set  = 1'b1;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction capture, timeout counter and load data register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_load_data <= 32'd0;
      r_abort     <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_launch) begin
          r_cnt       <= '0;
          r_we        <= mem_write;
          r_addr      <= {alu_out[31:2], 2'b00};
          r_wdata     <= w_wdata;
          r_be        <= w_be;
          r_funct3    <= funct3;
          r_off       <= alu_out[1:0];
          r_load_data <= 32'd0;
          r_abort     <= 1'b0;
        end
      end else if ((r_state == S_REQ) || (r_state == S_RESP)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_capture_load) begin
        r_load_data <= w_load_val;
      end
      if (w_abort_set) begin
        r_abort <= 1'b1;
      end
    end
  end

  assign dm_we    = r_we;
  assign dm_addr  = r_addr;
  assign dm_wdata = r_wdata;
  assign dm_be    = r_be;

  // --------------------------------------------------------------------------
  // MEM/WB pipeline register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data    <= 32'd0;
      rd_addr_wb <= 5'd0;
      wb_en_wb   <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_mem_op) begin
            wb_data    <= alu_out;
            rd_addr_wb <= rd_addr_mem;
            wb_en_wb   <= wb_en_mem;
          end else begin
            // Rejected access or launch cycle: bubble, data/rd held.
            wb_en_wb <= 1'b0;
            mem_err  <= w_err;
          end
        end
        S_DONE: begin
          rd_addr_wb <= rd_addr_mem;
          wb_data    <= r_we ? alu_out : r_load_data;
          wb_en_wb   <= (!r_we && !r_abort) ? wb_en_mem : 1'b0;
          mem_err    <= r_abort;
        end
        default: begin
          wb_en_wb <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
